piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of one_bit_mux.
- Accepts an N-bit word over a valid/ready handshake and holds it in a word register.
- Generates the mux select index, which steps once per accepted output bit, and emits one bit per transfer over a downstream valid/ready handshake.
- Forms the bit-serial transmit path: SPI-style shifters, LED/serial drivers.

Parameters:
- N, 32, word width in bits; power of 2, minimum 2.
- MSB_FIRST, 0, 0 = bit 0 first (index counts up); 1 = bit N-1 first (index counts down).
- W (localparam), $clog2(N), select/index width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- i_data  input  N  parallel word; sampled only on an input handshake.
- i_valid  input  1  upstream has a word.
- i_ready  output  1  block can accept a word.
- o_bit  output  1  current serial bit, equal to word[index] via a one_bit_mux instance.
- o_valid  output  1  o_bit is valid.
- o_ready  input  1  downstream accepts o_bit this cycle.
- o_last  output  1  o_bit is the final bit of the word.
- index  output  W  current select index, exported for debug/scope.

Behaviour:
- Reset: on a rising edge with rst=1, the next state is:
  - state=S_IDLE, word=0, index=(MSB_FIRST ? N-1 : 0).
  - Outputs: o_valid=0, o_last=0, o_bit=0, i_ready=1.
  - rst takes priority over every other event.
- States: S_IDLE, S_SHIFT. Encoding is free.
- Output decode: i_ready=(state==S_IDLE), o_valid=(state==S_SHIFT), o_bit=word[index] (combinational mux). o_last=o_valid and (index == end index).
  - End index is N-1 when MSB_FIRST=0, and 0 when MSB_FIRST=1.
- S_IDLE:
  - On i_valid & i_ready: word<=i_data, index<=start index, go to S_SHIFT.
  - Start index is 0 when MSB_FIRST=0, and N-1 when MSB_FIRST=1.
  - Otherwise hold.
- S_SHIFT:
  - On o_valid & o_ready with o_last=0: index steps by +1 (MSB_FIRST=0) or -1 (MSB_FIRST=1).
  - On o_valid & o_ready with o_last=1: go to S_IDLE. index returns to the start index; word is held.
  - With o_ready=0: o_bit, o_valid, o_last and index are held stable (AXI-style; no bit is ever dropped or repeated).
- Latency and throughput:
  - Word accepted at edge k → first bit valid in the cycle after edge k.
  - With o_ready tied high, bits appear on N consecutive cycles, then 1 idle cycle with i_ready=1.
  - Throughput is N+1 cycles per word. No back-to-back accept in the same cycle as the last bit, so there is no combinational path from o_ready to i_ready.
- Boundaries:
  - i_data/i_valid activity during S_SHIFT is ignored and the word register is never overwritten.
  - index never wraps past the end index.
  - i_valid=0 in S_IDLE → outputs stay idle indefinitely.
- Reset mid-word: the remaining bits are discarded. The next accepted word starts from the start index.
- No X on any output after the first reset edge.

Test Plan:
- Reset: hold rst=1 for 2 cycles, with i_valid=1 and i_data=8'hFF (N=8) → o_valid=0, o_last=0, o_bit=0, i_ready=1; no word accepted.
- LSB-first stream: N=8, MSB_FIRST=0, o_ready=1, present 8'hC1 for one cycle → bits 1,0,0,0,0,0,1,1 on 8 consecutive cycles, starting the cycle after accept. o_last is high only on the 8th bit; i_ready returns to 1 the next cycle.
- MSB-first stream: N=8, MSB_FIRST=1, same 8'hC1 → bits 1,1,0,0,0,0,0,1; index runs 7→0; o_last is high when index=0.
- Backpressure: LSB-first 8'hC1, drop o_ready for 3 cycles after the 2nd bit → o_bit=0, index=2 and o_valid=1 are held for those cycles. Full sequence is unchanged and completes in 11 cycles.
- Input ignored while busy: during a shift of 8'hC1, drive i_valid=1 with i_data=8'h3C → i_ready=0 throughout, emitted bits remain 8'hC1's. 8'h3C is accepted only in the S_IDLE cycle after o_last, then serialized correctly.
- Reset mid-word: assert rst for 1 cycle after 3 bits of 8'hC1 → next cycle o_valid=0 and i_ready=1. A following word 8'h01 (LSB-first) emits 1,0,0,0,0,0,0,0.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: latches an N-bit word on an input handshake and
// emits it one bit per output handshake, selecting the bit through one_bit_mux.

module one_bit_mux #(
   parameter int N = 32,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] data,
   input  logic [W-1:0] sel,
   output logic         y
);
   assign y = data[sel];
endmodule

module piso_serializer #(
   parameter int N         = 32,
   parameter int MSB_FIRST = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         i_data,
   input  logic                 i_valid,
   output logic                 i_ready,
   output logic                 o_bit,
   output logic                 o_valid,
   input  logic                 o_ready,
   output logic                 o_last,
   output logic [$clog2(N)-1:0] index
);
   localparam int W = $clog2(N);
   localparam logic [W-1:0] START_IDX = (MSB_FIRST != 0) ? W'(N - 1) : '0;
   localparam logic [W-1:0] END_IDX   = (MSB_FIRST != 0) ? '0 : W'(N - 1);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t         state, state_nxt;
   logic [N-1:0]   word, word_nxt;
   logic [W-1:0]   index_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         word  <= '0;
         index <= START_IDX;
      end else begin
         state <= state_nxt;
         word  <= word_nxt;
         index <= index_nxt;
      end
   end

   // Output decode depends only on registered state, so i_ready never sees o_ready.
   always_comb begin
      state_nxt = state;
      word_nxt  = word;
      index_nxt = index;
      i_ready   = (state == S_IDLE);
      o_valid   = (state == S_SHIFT);
      o_last    = (state == S_SHIFT) && (index == END_IDX);
      case (state)
         S_IDLE: begin
            if (i_valid) begin
               word_nxt  = i_data;
               index_nxt = START_IDX;
               state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (o_ready) begin
               if (o_last) begin
                  state_nxt = S_IDLE;
                  index_nxt = START_IDX;
               end else if (MSB_FIRST != 0) begin
                  index_nxt = index - 1'b1;
               end else begin
                  index_nxt = index + 1'b1;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   one_bit_mux #(.N(N), .W(W)) u_mux (
      .data (word),
      .sel  (index),
      .y    (o_bit)
   );
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: one LSB-first and one MSB-first instance (N=8),
// a bit scoreboard fed at stimulus time and drained on output handshakes.

module tb_piso_serializer;
   localparam int N = 8;

   typedef struct {
      logic       b;
      logic       last;
      logic [2:0] idx;
   } exp_t;

   logic       clk = 0;
   logic       rst = 1;
   logic [7:0] l_data = '0, m_data = '0;
   logic       l_valid = 0, m_valid = 0;
   logic       l_ready, m_ready;
   logic       l_bit, m_bit;
   logic       l_ovalid, m_ovalid;
   logic       l_oready = 1, m_oready = 1;
   logic       l_last, m_last;
   logic [2:0] l_index, m_index;

   exp_t q_l[$];
   exp_t q_m[$];
   exp_t el, em;
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   piso_serializer #(.N(N), .MSB_FIRST(0)) dut_l (
      .clk(clk), .rst(rst), .i_data(l_data), .i_valid(l_valid), .i_ready(l_ready),
      .o_bit(l_bit), .o_valid(l_ovalid), .o_ready(l_oready), .o_last(l_last), .index(l_index)
   );

   piso_serializer #(.N(N), .MSB_FIRST(1)) dut_m (
      .clk(clk), .rst(rst), .i_data(m_data), .i_valid(m_valid), .i_ready(m_ready),
      .o_bit(m_bit), .o_valid(m_ovalid), .o_ready(m_oready), .o_last(m_last), .index(m_index)
   );

   function automatic void push_l(input logic [7:0] d);
      for (int i = 0; i < N; i++) q_l.push_back('{b: d[i], last: (i == N-1), idx: 3'(i)});
   endfunction

   function automatic void push_m(input logic [7:0] d);
      for (int i = N-1; i >= 0; i--) q_m.push_back('{b: d[i], last: (i == 0), idx: 3'(i)});
   endfunction

   // Scoreboard drain: every output handshake must match the next expected bit.
   always @(negedge clk) begin
      if (!rst && l_ovalid && l_oready) begin
         total++;
         if (q_l.size() == 0) begin
            bad++;
            $display("FAIL lsb_unexpected got bit=%b last=%b idx=%0d, expected no output", l_bit, l_last, l_index);
         end else begin
            el = q_l.pop_front();
            if ({l_bit, l_last, l_index} !== {el.b, el.last, el.idx}) begin
               bad++;
               $display("FAIL lsb_bit got bit=%b last=%b idx=%0d, expected bit=%b last=%b idx=%0d",
                        l_bit, l_last, l_index, el.b, el.last, el.idx);
            end
         end
      end
      if (!rst && m_ovalid && m_oready) begin
         total++;
         if (q_m.size() == 0) begin
            bad++;
            $display("FAIL msb_unexpected got bit=%b last=%b idx=%0d, expected no output", m_bit, m_last, m_index);
         end else begin
            em = q_m.pop_front();
            if ({m_bit, m_last, m_index} !== {em.b, em.last, em.idx}) begin
               bad++;
               $display("FAIL msb_bit got bit=%b last=%b idx=%0d, expected bit=%b last=%b idx=%0d",
                        m_bit, m_last, m_index, em.b, em.last, em.idx);
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1; l_valid = 1; l_data = 8'hFF; m_valid = 1; m_data = 8'hFF;
      repeat (2) @(posedge clk);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         total++;
         if ({l_ovalid, l_last, l_bit, l_ready, l_index} !== {1'b0, 1'b0, 1'b0, 1'b1, 3'd0}) begin
            bad++;
            $display("FAIL reset_lsb got v=%b l=%b b=%b r=%b idx=%0d, expected 0 0 0 1 0",
                     l_ovalid, l_last, l_bit, l_ready, l_index);
         end
         total++;
         if ({m_ovalid, m_last, m_bit, m_ready, m_index} !== {1'b0, 1'b0, 1'b0, 1'b1, 3'd7}) begin
            bad++;
            $display("FAIL reset_msb got v=%b l=%b b=%b r=%b idx=%0d, expected 0 0 0 1 7",
                     m_ovalid, m_last, m_bit, m_ready, m_index);
         end
         @(posedge clk);
      end
      #1 rst = 0; l_valid = 0; m_valid = 0;
      repeat (3) begin
         @(negedge clk);
         total++;
         if ({l_ovalid, m_ovalid, l_ready, m_ready} !== 4'b0011) begin
            bad++;
            $display("FAIL idle_after_reset got lv=%b mv=%b lr=%b mr=%b, expected 0 0 1 1",
                     l_ovalid, m_ovalid, l_ready, m_ready);
         end
      end
   endtask

   task automatic test_lsb_stream();
      @(posedge clk); #1 l_data = 8'hC1; l_valid = 1; push_l(8'hC1);
      @(posedge clk); #1 l_valid = 0;
      for (int c = 0; c < N; c++) begin
         @(negedge clk);
         total++;
         if ({l_ovalid, l_last, l_ready} !== {1'b1, c == N-1, 1'b0}) begin
            bad++;
            $display("FAIL lsb_stream_c%0d got v=%b last=%b r=%b, expected 1 %b 0", c, l_ovalid, l_last, l_ready, c == N-1);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      total++;
      if ({l_ready, l_ovalid} !== 2'b10) begin
         bad++;
         $display("FAIL lsb_stream_end got r=%b v=%b, expected 1 0", l_ready, l_ovalid);
      end
   endtask

   task automatic test_msb_stream();
      @(posedge clk); #1 m_data = 8'hC1; m_valid = 1; push_m(8'hC1);
      @(posedge clk); #1 m_valid = 0;
      for (int c = 0; c < N; c++) begin
         @(negedge clk);
         total++;
         if ({m_ovalid, m_last, m_index} !== {1'b1, c == N-1, 3'(N-1-c)}) begin
            bad++;
            $display("FAIL msb_stream_c%0d got v=%b last=%b idx=%0d, expected 1 %b %0d",
                     c, m_ovalid, m_last, m_index, c == N-1, N-1-c);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      total++;
      if ({m_ready, m_ovalid} !== 2'b10) begin
         bad++;
         $display("FAIL msb_stream_end got r=%b v=%b, expected 1 0", m_ready, m_ovalid);
      end
   endtask

   task automatic test_backpressure();
      @(posedge clk); #1 l_data = 8'hC1; l_valid = 1; push_l(8'hC1);
      @(posedge clk); #1 l_valid = 0;
      for (int c = 0; c < N + 3; c++) begin
         l_oready = !(c >= 2 && c <= 4);
         @(negedge clk);
         if (c >= 2 && c <= 4) begin
            total++;
            if ({l_ovalid, l_bit, l_index, l_last} !== {1'b1, 1'b0, 3'd2, 1'b0}) begin
               bad++;
               $display("FAIL bp_hold_c%0d got v=%b b=%b idx=%0d last=%b, expected 1 0 2 0",
                        c, l_ovalid, l_bit, l_index, l_last);
            end
         end
         if (c == N + 2) begin
            total++;
            if (l_last !== 1'b1) begin
               bad++;
               $display("FAIL bp_last_cycle got last=%b, expected 1", l_last);
            end
         end
         @(posedge clk); #1;
      end
      l_oready = 1;
      @(negedge clk);
      total++;
      if ({l_ready, l_ovalid} !== 2'b10) begin
         bad++;
         $display("FAIL bp_end got r=%b v=%b, expected 1 0", l_ready, l_ovalid);
      end
   endtask

   task automatic test_busy_ignore();
      @(posedge clk); #1 l_data = 8'hC1; l_valid = 1; push_l(8'hC1);
      @(posedge clk); #1 l_data = 8'h3C; push_l(8'h3C);
      for (int c = 0; c < N; c++) begin
         @(negedge clk);
         total++;
         if ({l_ready, l_ovalid} !== 2'b01) begin
            bad++;
            $display("FAIL busy_ready_c%0d got r=%b v=%b, expected 0 1", c, l_ready, l_ovalid);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      total++;
      if ({l_ready, l_ovalid} !== 2'b10) begin
         bad++;
         $display("FAIL busy_idle_gap got r=%b v=%b, expected 1 0", l_ready, l_ovalid);
      end
      @(posedge clk); #1 l_valid = 0;
      for (int c = 0; c < N; c++) begin
         @(negedge clk);
         total++;
         if (l_ovalid !== 1'b1) begin
            bad++;
            $display("FAIL busy_second_c%0d got v=%b, expected 1", c, l_ovalid);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_word();
      @(posedge clk); #1 l_data = 8'hC1; l_valid = 1; push_l(8'hC1);
      @(posedge clk); #1 l_valid = 0;
      repeat (3) begin
         @(negedge clk);
         @(posedge clk); #1;
      end
      rst = 1; q_l.delete();
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      total++;
      if ({l_ovalid, l_ready, l_index, l_bit} !== {1'b0, 1'b1, 3'd0, 1'b0}) begin
         bad++;
         $display("FAIL rst_mid got v=%b r=%b idx=%0d b=%b, expected 0 1 0 0", l_ovalid, l_ready, l_index, l_bit);
      end
      @(posedge clk); #1 l_data = 8'h01; l_valid = 1; push_l(8'h01);
      @(posedge clk); #1 l_valid = 0;
      for (int c = 0; c < N + 1; c++) begin
         @(negedge clk);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_lsb_stream();
      test_msb_stream();
      test_backpressure();
      test_busy_ignore();
      test_reset_mid_word();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (q_l.size() != 0 || q_m.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain got lsb_left=%0d msb_left=%0d, expected 0 0", q_l.size(), q_m.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got run still active, expected finish");
      $fatal(1);
   end
endmodule
